// File: rtl/conv_pkg.sv
// Shared definitions for the convolution mode sequencer: mode encodings,
// sequencer states and the default drain length.
package conv_pkg;

    localparam int unsigned MODE_CONV      = 0;
    localparam int unsigned MODE_TRANSCONV = 1;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_FLUSH     = 3'd3,
        ST_ARM       = 3'd4
    } seq_state_e;

    // A zero wavefront must cross both array dimensions plus one register stage.
    function automatic int unsigned drain_cycles_default(input int unsigned dim);
        return 2 * dim + 1;
    endfunction

endpackage

// File: rtl/conv_mode_sequencer_if.sv
// Bundle of request handshake, per-mode source buses and array-side outputs
// of the mode sequencer.
interface conv_mode_sequencer_if #(
    parameter int unsigned DW        = 16,
    parameter int unsigned Dimension = 16,
    parameter int unsigned NUM_MODES = 2,
    parameter int unsigned MODE_W    = 2
);
    localparam int unsigned BW = DW * Dimension;

    logic [MODE_W-1:0]       mode_req;
    logic                    mode_req_valid;
    logic                    mode_req_ready;
    logic                    mode_req_err;
    logic                    src_busy;
    logic [NUM_MODES*BW-1:0] weight_in_bus;
    logic [NUM_MODES*BW-1:0] ifmap_in_bus;
    logic [NUM_MODES-1:0]    in_valid;
    logic [BW-1:0]           weight_to_array;
    logic [BW-1:0]           ifmap_to_array;
    logic                    array_valid;
    logic [NUM_MODES-1:0]    ctrl_enable;
    logic                    array_flush;
    logic [MODE_W-1:0]       active_mode;
    logic                    switching;
    logic                    switch_done;

    modport master (
        output mode_req, mode_req_valid, src_busy, weight_in_bus, ifmap_in_bus, in_valid,
        input  mode_req_ready, mode_req_err, weight_to_array, ifmap_to_array, array_valid,
               ctrl_enable, array_flush, active_mode, switching, switch_done
    );

    modport slave (
        input  mode_req, mode_req_valid, src_busy, weight_in_bus, ifmap_in_bus, in_valid,
        output mode_req_ready, mode_req_err, weight_to_array, ifmap_to_array, array_valid,
               ctrl_enable, array_flush, active_mode, switching, switch_done
    );

endinterface

// File: rtl/conv_mode_data_reg.sv
// Selects the active mode's weight/ifmap slice and registers it toward the
// array, with hold, force-zero (drain) and valid generation.
module conv_mode_data_reg #(
    parameter int unsigned DW        = 16,
    parameter int unsigned Dimension = 16,
    parameter int unsigned NUM_MODES = 2,
    parameter int unsigned MODE_W    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [MODE_W-1:0]                    i_sel,
    input  logic                                 i_load,
    input  logic                                 i_zero,
    input  logic [NUM_MODES*DW*Dimension-1:0]    i_weight_bus,
    input  logic [NUM_MODES*DW*Dimension-1:0]    i_ifmap_bus,
    output logic [DW*Dimension-1:0]              o_weight,
    output logic [DW*Dimension-1:0]              o_ifmap,
    output logic                                 o_valid
);
    localparam int unsigned BW = DW * Dimension;

    logic [BW-1:0] w_weight_sel;
    logic [BW-1:0] w_ifmap_sel;
    logic [BW-1:0] r_weight;
    logic [BW-1:0] r_ifmap;
    logic          r_valid;

    always_comb begin
        w_weight_sel = '0;
        w_ifmap_sel  = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (i_sel == MODE_W'(m)) begin
                w_weight_sel = i_weight_bus[m*BW +: BW];
                w_ifmap_sel  = i_ifmap_bus[m*BW +: BW];
            end
        end
    end

    // Drain zeros take priority; they are still flagged valid so they propagate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_weight <= '0;
            r_ifmap  <= '0;
            r_valid  <= 1'b0;
        end else if (i_zero) begin
            r_weight <= '0;
            r_ifmap  <= '0;
            r_valid  <= 1'b1;
        end else if (i_load) begin
            r_weight <= w_weight_sel;
            r_ifmap  <= w_ifmap_sel;
            r_valid  <= 1'b1;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign o_weight = r_weight;
    assign o_ifmap  = r_ifmap;
    assign o_valid  = r_valid;

endmodule

// File: rtl/conv_mode_sequencer.sv
// Multi-mode front end of the convolution array: muxes the active mode's data
// into the array and sequences mode changes through wait-idle, drain, flush, arm.
module conv_mode_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned DW           = 16,
    parameter int unsigned Dimension    = 16,
    parameter int unsigned NUM_MODES    = 2,
    parameter int unsigned MODE_W       = 2,
    parameter int unsigned DRAIN_CYCLES = drain_cycles_default(Dimension),
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    conv_mode_sequencer_if.slave  bus_if
);
    localparam int unsigned BW     = DW * Dimension;
    localparam int unsigned MAX_PH = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_PH) + 1;

    seq_state_e           r_state, w_state_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [MODE_W-1:0]    r_pending, w_pending_n;
    logic [MODE_W-1:0]    r_active_mode, w_active_n;
    logic [NUM_MODES-1:0] r_ctrl_enable, w_enable_n;
    logic [NUM_MODES-1:0] w_onehot;
    logic                 r_ready, r_err, r_done, r_flush, r_switching;
    logic                 w_err_n, w_done_n;
    logic                 w_req_bad, w_active_valid, w_load, w_zero;
    logic [BW-1:0]        w_weight, w_ifmap;
    logic                 w_array_valid;

    always_comb begin
        w_req_bad      = 32'(bus_if.mode_req) >= NUM_MODES;
        w_active_valid = 1'b0;
        w_onehot       = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (r_active_mode == MODE_W'(m)) w_active_valid = bus_if.in_valid[m];
            w_onehot[m] = (r_pending == MODE_W'(m));
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_pending_n = r_pending;
        w_active_n  = r_active_mode;
        w_enable_n  = r_ctrl_enable;
        w_err_n     = 1'b0;
        w_done_n    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (bus_if.mode_req_valid) begin
                    if (w_req_bad) begin
                        w_err_n = 1'b1;
                    end else if (bus_if.mode_req == r_active_mode) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_pending_n = bus_if.mode_req;
                        w_state_n   = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (!bus_if.src_busy) begin
                    w_state_n  = ST_DRAIN;
                    w_cnt_n    = CNT_W'(DRAIN_CYCLES - 1);
                    w_enable_n = '0;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_n = ST_FLUSH;
                    w_cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_n  = ST_ARM;
                    w_active_n = r_pending;
                    w_enable_n = w_onehot;
                    w_done_n   = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            ST_ARM: begin
                w_state_n = ST_RUN;
            end
            default: begin
                w_state_n = ST_RUN;
            end
        endcase
        w_load = (r_state == ST_RUN) && w_active_valid;
        w_zero = (w_state_n == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_pending     <= '0;
            r_active_mode <= MODE_W'(MODE_CONV);
            r_ctrl_enable <= NUM_MODES'(1);
            r_ready       <= 1'b1;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_flush       <= 1'b0;
            r_switching   <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_pending     <= w_pending_n;
            r_active_mode <= w_active_n;
            r_ctrl_enable <= w_enable_n;
            r_ready       <= (w_state_n == ST_RUN);
            r_err         <= w_err_n;
            r_done        <= w_done_n;
            r_flush       <= (w_state_n == ST_FLUSH);
            r_switching   <= (w_state_n != ST_RUN);
        end
    end

    conv_mode_data_reg #(
        .DW        (DW),
        .Dimension (Dimension),
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_data_reg (
        .clk          (clk),
        .rst          (rst),
        .i_sel        (r_active_mode),
        .i_load       (w_load),
        .i_zero       (w_zero),
        .i_weight_bus (bus_if.weight_in_bus),
        .i_ifmap_bus  (bus_if.ifmap_in_bus),
        .o_weight     (w_weight),
        .o_ifmap      (w_ifmap),
        .o_valid      (w_array_valid)
    );

    assign bus_if.mode_req_ready  = r_ready;
    assign bus_if.mode_req_err    = r_err;
    assign bus_if.switch_done     = r_done;
    assign bus_if.array_flush     = r_flush;
    assign bus_if.switching       = r_switching;
    assign bus_if.active_mode     = r_active_mode;
    assign bus_if.ctrl_enable     = r_ctrl_enable;
    assign bus_if.weight_to_array = w_weight;
    assign bus_if.ifmap_to_array  = w_ifmap;
    assign bus_if.array_valid     = w_array_valid;

endmodule

// File: doc/conv_mode_sequencer.md
# conv_mode_sequencer

Parametrised multi-mode front end for the unified convolution array. It selects one of NUM_MODES data sources, such as 1DCONV buffers or TRANSCONV direct inputs, and registers that source into the array. It also arbitrates mode-change requests with a safe switch sequence: wait for the owning control top to go idle, drain the array with zeros, pulse a synchronous flush, then hand control to the new mode. It sits between the per-mode control tops/buffers and the systolic array.

## Interface
- DW, 16, element width
- Dimension, 16, array dimension (lanes per bus)
- NUM_MODES, 2, number of selectable modes (2..4)
- MODE_W, 2, mode index width
- DRAIN_CYCLES, 33, zero-feed cycles before flush (≥1; nominal 2*Dimension+1)
- FLUSH_CYCLES, 2, array_flush pulse length (≥1)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mode_req  in  MODE_W  requested mode
- mode_req_valid  in  1  request strobe
- mode_req_ready  out  1  request accepted when valid&ready
- mode_req_err  out  1  1-cycle pulse: requested mode ≥ NUM_MODES
- src_busy  in  1  active mode's control top still issuing
- weight_in_bus  in  NUM_MODES*DW*Dimension  per-mode weight buses; mode m at slice m
- ifmap_in_bus  in  NUM_MODES*DW*Dimension  per-mode ifmap buses
- in_valid  in  NUM_MODES  per-mode data valid
- weight_to_array  out  DW*Dimension  registered weight to array
- ifmap_to_array  out  DW*Dimension  registered ifmap to array
- array_valid  out  1  outputs carry new data this cycle
- ctrl_enable  out  NUM_MODES  one-hot enable to the owning control top
- array_flush  out  1  synchronous clear for array/buffers
- active_mode  out  MODE_W  current mode
- switching  out  1  high in every state except RUN
- switch_done  out  1  1-cycle pulse when a request completes

## Operation
- States: RUN, WAIT_IDLE, DRAIN, FLUSH, ARM.
- Reset values: state RUN, active_mode 0, ctrl_enable 1, data outputs 0, all flags 0.
- RUN:
  - mode_req_ready=1.
  - On accept with mode_req ≥ NUM_MODES: mode_req_err pulses next cycle; state stays RUN.
  - On accept with mode_req == active_mode: switch_done pulses next cycle; no flush.
  - On any other accept: latch pending_mode and go to WAIT_IDLE.
- WAIT_IDLE: ctrl_enable is held. Leave for DRAIN on the first edge where src_busy=0.
- DRAIN: ctrl_enable=0; data outputs forced 0; array_valid=1 so zeros propagate. Lasts DRAIN_CYCLES; src_busy ignored.
- FLUSH: array_flush=1, array_valid=0. Lasts FLUSH_CYCLES.
- ARM (1 cycle):
  - active_mode←pending_mode; ctrl_enable←one-hot(pending_mode).
  - Pulse switch_done, then go to RUN.
- Datapath in RUN, m=active_mode:
  - When in_valid[m]=1: register slice m of both buses and set array_valid=1.
  - Otherwise hold the outputs and set array_valid=0.
  - in_valid of non-active modes is ignored.
- Outside RUN: mode_req_valid and all in_valid are ignored; mode_req_ready=0.
- rst in any state: immediate return to reset values; pending request discarded.

## Timing
- Datapath latency is 1 cycle from in_valid to array_valid.
- Handshake: a request is accepted at edge T when valid&ready. switching=1 from T+1.
- Minimum switch duration with src_busy already low:
  - WAIT_IDLE 1 + DRAIN 33 + FLUSH 2 + ARM 1 = 37 cycles (defaults).
  - switch_done is high in cycle T+37; mode_req_ready returns at T+38.
- Each cycle of src_busy=1 in WAIT_IDLE adds one cycle.
- ctrl_enable is all-zero from the first DRAIN cycle through the last FLUSH cycle. It never has more than one bit set.
- mode_req_err and switch_done never coincide.

## Structure
- Shared package conv_pkg holds:
  - MODE_CONV=0 and MODE_TRANSCONV=1 mode encodings;
  - the sequencer state enum;
  - DRAIN_CYCLES default derivation (2*Dimension+1).
- One sub-module: conv_mode_data_reg. It is the per-lane slice select plus output register, with hold, force-zero and valid logic.
- FSM and phase counter (width $clog2(max(DRAIN,FLUSH))+1) live in the top.

## Test plan
- Reset, then mode 0, in_valid=01, weight lane0=0x0005 -> weight_to_array lane0=0x0005 and array_valid=1 one cycle later; ctrl_enable=01.
- Request mode 1 with src_busy=0 -> switching for 37 cycles; array_flush high exactly 2 cycles; switch_done at T+37; active_mode=1; ctrl_enable=10; outputs 0 during DRAIN.
- Request mode 1 with src_busy held high 10 cycles -> ctrl_enable stays 01 through WAIT_IDLE; switch completes at T+47.
- Request mode 3 with NUM_MODES=2 -> mode_req_err pulses once; state stays RUN; active_mode unchanged. Request for the current mode -> switch_done only, no array_flush.
- rst asserted mid-DRAIN -> next cycle state RUN, active_mode 0, ctrl_enable 01, array_flush 0, pending request lost.
- in_valid[1]=1 while active_mode=0, and mode_req_valid during DRAIN -> no output change, no acceptance.
